// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard unit: forward-select encodings and
// the default ResultSrc value that marks a load.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W_DEF      = 5;
  localparam logic [1:0]  RESULT_SRC_LOAD_DEF = 2'b01;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow D->E->M->W register-address/valid pipeline. A flush into Execute
// injects a bubble (zero addresses, valid cleared); M and W always advance.
module hazard_shadow_pipe #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flushE,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  output logic [REG_ADDR_W-1:0] Rs1E,
  output logic [REG_ADDR_W-1:0] Rs2E,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic                  validE,
  output logic [REG_ADDR_W-1:0] RdM,
  output logic                  validM,
  output logic [REG_ADDR_W-1:0] RdW,
  output logic                  validW
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      Rs1E   <= '0;
      Rs2E   <= '0;
      RdE    <= '0;
      validE <= 1'b0;
      RdM    <= '0;
      validM <= 1'b0;
      RdW    <= '0;
      validW <= 1'b0;
    end else begin
      if (flushE) begin
        Rs1E   <= '0;
        Rs2E   <= '0;
        RdE    <= '0;
        validE <= 1'b0;
      end else begin
        Rs1E   <= Rs1D;
        Rs2E   <= Rs2D;
        RdE    <= RdD;
        validE <= 1'b1;
      end
      RdM    <= RdE;
      validM <= validE;
      RdW    <= RdM;
      validW <= validM;
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard unit for the 5-stage RV32I core: forwarding, load-use stall and
// branch flush. Define HAZARD_PERF_CNT_EN to build the stall/flush counters.
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W      = REG_ADDR_W_DEF,
  parameter logic [1:0]  RESULT_SRC_LOAD = RESULT_SRC_LOAD_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  PCSrcE,
  input  logic [1:0]            ResultSrcE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic [31:0]           StallCnt,
  output logic [31:0]           FlushCnt
);

  logic [REG_ADDR_W-1:0] rs1E, rs2E, rdE, rdM, rdW;
  logic                  validE, validM, validW;
  logic                  wrM, wrW, lwStall;
  logic                  stallInt, flushDInt, flushEInt;
  fwd_sel_e              fwdA, fwdB;

  hazard_shadow_pipe #(
    .REG_ADDR_W(REG_ADDR_W)
  ) uShadow (
    .clk   (clk),
    .resetn(resetn),
    .flushE(flushEInt),
    .Rs1D  (Rs1D),
    .Rs2D  (Rs2D),
    .RdD   (RdD),
    .Rs1E  (rs1E),
    .Rs2E  (rs2E),
    .RdE   (rdE),
    .validE(validE),
    .RdM   (rdM),
    .validM(validM),
    .RdW   (rdW),
    .validW(validW)
  );

  // Nonzero-rd gating here is what keeps x0 from ever being forwarded.
  assign wrM = RegWriteM & validM & (rdM != '0);
  assign wrW = RegWriteW & validW & (rdW != '0);

  always_comb begin
    fwdA = FWD_RF;
    fwdB = FWD_RF;
    if (wrM && (rs1E == rdM))      fwdA = FWD_M;
    else if (wrW && (rs1E == rdW)) fwdA = FWD_W;
    if (wrM && (rs2E == rdM))      fwdB = FWD_M;
    else if (wrW && (rs2E == rdW)) fwdB = FWD_W;
  end

  assign lwStall = validE & (ResultSrcE == RESULT_SRC_LOAD) & (rdE != '0)
                 & ((rdE == Rs1D) | (rdE == Rs2D));

  // A taken branch overrides a load-use stall.
  assign stallInt  = lwStall & ~PCSrcE;
  assign flushDInt = PCSrcE;
  assign flushEInt = lwStall | PCSrcE;

  assign StallF    = resetn & stallInt;
  assign StallD    = resetn & stallInt;
  assign FlushD    = resetn & flushDInt;
  assign FlushE    = resetn & flushEInt;
  assign ForwardAE = resetn ? fwdA : FWD_RF;
  assign ForwardBE = resetn ? fwdB : FWD_RF;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt, flushCnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stallInt)              stallCnt <= stallCnt + 32'd1;
      if (flushDInt | flushEInt) flushCnt <= flushCnt + 32'd1;
    end
  end

  assign StallCnt = stallCnt;
  assign FlushCnt = flushCnt;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule
